// File: rtl/lb_8bit_rd_fifo.sv
// Read-side local-bus FIFO peripheral for PicoBlaze: an external producer pushes bytes,
// the CPU pops them at DATA_ADDR and polls/clears status at STAT_ADDR, with a data-arrival irq.
module lb_8bit_rd_fifo #(
    parameter logic [7:0] DATA_ADDR  = 8'h10,
    parameter logic [7:0] STAT_ADDR  = 8'h11,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       wr_full,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       irq,
    input  logic       irq_ack
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  overflow;
    logic                  empty;
    logic                  full;
    logic                  data_sel;
    logic                  stat_sel;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [7:0]            status;
    logic [7:0]            rd_mux;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign data_sel = (port_id == DATA_ADDR);
    assign stat_sel = (port_id == STAT_ADDR);
    assign pop      = read_strobe & data_sel & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push     = wr_en & (~full | pop);
    assign drop     = wr_en & full & ~pop;
    assign status   = {4'b0000, irq, overflow, full, empty};

    always_comb begin
        rd_mux = 8'h00;
        if (data_sel) begin
            rd_mux = empty ? 8'h00 : mem[rd_ptr];
        end else if (stat_sel) begin
            rd_mux = status;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
            in_port  <= 8'h00;
            wr_full  <= 1'b0;
        end else begin
            in_port <= rd_mux;
            count   <= count_next;
            wr_full <= (count_next == CNT_FULL);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A fresh drop outranks the clear-on-read of the status register.
            if (drop) begin
                overflow <= 1'b1;
            end else if (read_strobe & stat_sel) begin
                overflow <= 1'b0;
            end
            if (push & empty) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lb_8bit_rd_fifo.sv
// Bench for lb_8bit_rd_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_lb_8bit_rd_fifo;
    localparam logic [7:0] DATA_ADDR = 8'h10;
    localparam logic [7:0] STAT_ADDR = 8'h11;
    localparam int         DEPTH     = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       wr_full;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port;
    logic       irq;
    logic       irq_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    lb_8bit_rd_fifo #(.DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
        .port_id(port_id), .read_strobe(read_strobe), .in_port(in_port),
        .irq(irq), .irq_ack(irq_ack)
    );

    // Reference model: the FIFO is a plain queue of bytes.
    logic [7:0] mq[$];
    logic       m_irq = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_full = 1'b0;
    logic [7:0] m_in = 8'h00;
    int         m_n;
    logic       m_pop, m_push, m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_irq = 1'b0;
            m_ovf = 1'b0;
            m_full = 1'b0;
            m_in = 8'h00;
        end else begin
            m_n = mq.size();
            if (port_id == DATA_ADDR)
                m_in = (m_n > 0) ? mq[0] : 8'h00;
            else if (port_id == STAT_ADDR)
                m_in = {4'b0000, m_irq, m_ovf, (m_n == DEPTH), (m_n == 0)};
            else
                m_in = 8'h00;
            m_pop  = read_strobe && port_id == DATA_ADDR && m_n > 0;
            m_push = wr_en && (m_n < DEPTH || m_pop);
            m_drop = wr_en && !m_push;
            if (m_push && m_n == 0) m_irq = 1'b1;
            else if (irq_ack) m_irq = 1'b0;
            if (m_drop) m_ovf = 1'b1;
            else if (read_strobe && port_id == STAT_ADDR) m_ovf = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(wr_data);
            m_full = (mq.size() == DEPTH);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (in_port !== m_in || irq !== m_irq || wr_full !== m_full) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t in_port=%h/%h irq=%b/%b wr_full=%b/%b (actual/required)",
                         $time, in_port, m_in, irq, m_irq, wr_full, m_full);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] model,
                       input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut: actual=%h required=%h", name, act, exp);
        end
        vectors++;
        if (model !== exp) begin
            miscompares++;
            $display("FAIL %s model: actual=%h required=%h", name, model, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic read_port(input logic [7:0] addr, output logic [7:0] v, output logic [7:0] mv);
        port_id = addr;
        read_strobe = 1'b0;
        cyc();
        read_strobe = 1'b1;
        v = in_port;
        mv = m_in;
        cyc();
        read_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    logic [7:0] v, mv;
    int wp;

    initial begin
        #1 reset = 1'b0;
        started = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        // Reset mid-fill
        push(8'h11); push(8'h22); push(8'h33);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        read_port(STAT_ADDR, v, mv); chk("rst_status", v, mv, 8'h01);
        read_port(DATA_ADDR, v, mv); chk("rst_data", v, mv, 8'h00);
        chk("rst_irq", {7'd0, irq}, {7'd0, m_irq}, 8'h00);

        // Single byte, irq and ack
        push(8'hA5);
        chk("irq_set", {7'd0, irq}, {7'd0, m_irq}, 8'h01);
        read_port(DATA_ADDR, v, mv); chk("data_a5", v, mv, 8'hA5);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("irq_ack", {7'd0, irq}, {7'd0, m_irq}, 8'h00);

        // Fill, overflow, clear-on-read
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("wr_full", {7'd0, wr_full}, {7'd0, m_full}, 8'h01);
        read_port(STAT_ADDR, v, mv); chk("full_status", v, mv, 8'h0A);
        push(8'hFF);
        read_port(STAT_ADDR, v, mv); chk("ovf_status", v, mv, 8'h0E);
        read_port(STAT_ADDR, v, mv); chk("ovf_cleared", v, mv, 8'h0A);

        // Drain in order, then pop on empty
        for (int i = 0; i < 16; i++) begin
            read_port(DATA_ADDR, v, mv);
            chk($sformatf("drain_%0d", i), v, mv, 8'(i));
        end
        read_port(STAT_ADDR, v, mv); chk("empty_status", v, mv, 8'h09);
        read_port(DATA_ADDR, v, mv); chk("pop_empty", v, mv, 8'h00);
        read_port(STAT_ADDR, v, mv); chk("still_empty", v, mv, 8'h09);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        port_id = DATA_ADDR;
        cyc();
        read_strobe = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h77;
        v = in_port;
        mv = m_in;
        cyc();
        read_strobe = 1'b0;
        wr_en = 1'b0;
        port_id = 8'h00;
        chk("pp_head", v, mv, 8'h30);
        chk("pp_full", {7'd0, wr_full}, {7'd0, m_full}, 8'h01);
        read_port(STAT_ADDR, v, mv); chk("pp_status", v, mv, 8'h0A);
        for (int i = 1; i < 16; i++) begin
            read_port(DATA_ADDR, v, mv);
            chk($sformatf("pp_drain_%0d", i), v, mv, 8'h30 + 8'(i));
        end
        read_port(DATA_ADDR, v, mv); chk("pp_last_77", v, mv, 8'h77);

        // Unmapped address
        push(8'h5C);
        read_port(8'h20, v, mv); chk("unmapped", v, mv, 8'h00);
        read_port(STAT_ADDR, v, mv); chk("unmapped_status", v, mv, 8'h08);
        read_port(DATA_ADDR, v, mv); chk("unmapped_data", v, mv, 8'h5C);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            case (i / 500)
                0: wp = 80;
                1: wp = 25;
                2: wp = 60;
                default: wp = 45;
            endcase
            wr_en = ($urandom_range(0, 99) < wp);
            wr_data = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1, 2: port_id = DATA_ADDR;
                3, 4:    port_id = STAT_ADDR;
                default: port_id = 8'h20;
            endcase
            read_strobe = ($urandom_range(0, 2) == 0);
            irq_ack = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) != 0);
            cyc();
        end
        reset = 1'b1;
        wr_en = 1'b0;
        read_strobe = 1'b0;
        irq_ack = 1'b0;
        cyc();
        cyc();
        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
